// File: rtl/token_precision_assign_if.sv
// Attention-element stream: one unsigned element per a_valid && a_ready beat.
// Latency: none, wires only.
// Backpressure: the master holds a_data while a_valid is high and a_ready is low.
interface token_precision_assign_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  a_valid;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_ready;

    modport master (output a_valid, output a_data, input a_ready);
    modport slave  (input a_valid, input a_data, output a_ready);
endinterface

// File: rtl/token_precision_assign.sv
// Tracks per-key-token attention maxima over a frame and maps each to INT4/INT8/full16 codes.
// Latency: start at T, K=L*N*L beats, L classify cycles, done pulse at T+K+L+1 (a_valid held high).
// Backpressure: a_ready is high only while loading; idle a_valid cycles stall the frame without loss.
module token_precision_assign #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    L          = 8,
    parameter int                    N          = 1,
    parameter logic [DATA_WIDTH-1:0] THR_INT4   = 16'h1000,
    parameter logic [DATA_WIDTH-1:0] THR_INT8   = 16'h4000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   force_full,
    token_precision_assign_if.slave a_if,
    output logic                   busy,
    output logic [3:0]             token_precision [L-1:0],
    output logic [$clog2(L+1)-1:0] int4_count,
    output logic                   prec_valid,
    output logic                   done
);

    localparam int K      = L * N * L;
    localparam int IDX_W  = $clog2(L);
    localparam int BEAT_W = $clog2(K);

    if (THR_INT4 > THR_INT8) begin : g_thr_err
        $error("token_precision_assign: THR_INT4 must not exceed THR_INT8");
    end
    if (L < 2) begin : g_len_err
        $error("token_precision_assign: L must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CLASSIFY,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic                  force_full_q;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [IDX_W-1:0]      col;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] colmax [L-1:0];
    logic                  xfer;
    logic                  last_beat;
    logic                  last_idx;
    logic [3:0]            code_nxt;

    assign xfer      = a_if.a_valid && a_if.a_ready;
    assign last_beat = (beat_cnt == BEAT_W'(K - 1));
    assign last_idx  = (idx == IDX_W'(L - 1));

    always_comb begin
        state_nxt   = state;
        a_if.a_ready = 1'b0;
        busy        = (state != S_IDLE);
        done        = 1'b0;
        unique case (state)
            S_IDLE:     if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                a_if.a_ready = 1'b1;
                if (xfer && last_beat) state_nxt = S_CLASSIFY;
            end
            S_CLASSIFY: if (last_idx) state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Strict '<' so a maximum sitting exactly on a threshold gets the wider format.
    always_comb begin
        code_nxt = 4'd2;
        if (!force_full_q) begin
            if (colmax[idx] < THR_INT4)      code_nxt = 4'd0;
            else if (colmax[idx] < THR_INT8) code_nxt = 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            force_full_q <= 1'b0;
            beat_cnt     <= '0;
            col          <= '0;
            idx          <= '0;
            int4_count   <= '0;
            prec_valid   <= 1'b0;
            for (int i = 0; i < L; i++) begin
                colmax[i]          <= '0;
                token_precision[i] <= 4'd2;
            end
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: if (start) begin
                    force_full_q <= force_full;
                    beat_cnt     <= '0;
                    col          <= '0;
                    idx          <= '0;
                    int4_count   <= '0;
                    prec_valid   <= 1'b0;
                    for (int i = 0; i < L; i++) colmax[i] <= '0;
                end
                S_LOAD: if (xfer) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    col      <= (col == IDX_W'(L - 1)) ? '0 : col + 1'b1;
                    if (a_if.a_data > colmax[col]) colmax[col] <= a_if.a_data;
                end
                S_CLASSIFY: begin
                    token_precision[idx] <= code_nxt;
                    if (code_nxt == 4'd0) int4_count <= int4_count + 1'b1;
                    idx <= last_idx ? '0 : idx + 1'b1;
                    // Raised with the last write so codes and prec_valid appear together with done.
                    if (last_idx) prec_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_token_precision_assign.sv
// Scoreboard bench for token_precision_assign at L=4, N=1: expected codes are queued at start
// and compared when done fires.
module tb_token_precision_assign;

    localparam int L  = 4;
    localparam int K  = 16;
    localparam int CW = $clog2(L + 1);

    typedef struct packed {
        logic [15:0]   codes;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          force_full;
    logic          busy;
    logic [3:0]    token_precision [L-1:0];
    logic [CW-1:0] int4_count;
    logic          prec_valid;
    logic          done;

    token_precision_assign_if #(.DATA_WIDTH(16)) a_if ();

    token_precision_assign #(
        .DATA_WIDTH(16), .L(L), .N(1), .THR_INT4(16'h1000), .THR_INT8(16'h4000)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .force_full(force_full), .a_if(a_if),
        .busy(busy), .token_precision(token_precision), .int4_count(int4_count),
        .prec_valid(prec_valid), .done(done)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] frame_data [K];
    exp_t        sb_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Row r, column c: the column maximum sits in one row, every other row holds smaller values.
    task automatic set_cols(input logic [15:0] m0, m1, m2, m3);
        logic [15:0] m [4];
        m[0] = m0; m[1] = m1; m[2] = m2; m[3] = m3;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                frame_data[r*4+c] = (r == (c + 1) % 4) ? m[c] : (m[c] >> (1 + r));
    endtask

    function automatic exp_t model(input bit ff);
        logic [15:0] mx [4];
        logic [3:0]  code;
        exp_t        e;
        e = '0;
        for (int c = 0; c < 4; c++) mx[c] = 16'h0;
        for (int b = 0; b < K; b++) if (frame_data[b] > mx[b % 4]) mx[b % 4] = frame_data[b];
        for (int c = 0; c < 4; c++) begin
            if (ff)                  code = 4'd2;
            else if (mx[c] < 16'h1000) code = 4'd0;
            else if (mx[c] < 16'h4000) code = 4'd1;
            else                     code = 4'd2;
            e.codes[c*4 +: 4] = code;
            if (code == 4'd0) e.cnt = e.cnt + 1'b1;
        end
        return e;
    endfunction

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; force_full = 1'b0;
        a_if.a_valid = 1'b0; a_if.a_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < L; i++) begin
            vectors++;
            if (token_precision[i] !== 4'd2) begin
                miscompares++;
                $display("FAIL reset_code[%0d]: got %0d want 2", i, token_precision[i]);
            end
        end
        vectors++;
        if ({prec_valid, done, a_if.a_ready, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags {pv,done,rdy,busy}: got %b want 0000",
                     {prec_valid, done, a_if.a_ready, busy});
        end
        vectors++;
        if (int4_count !== '0) begin
            miscompares++;
            $display("FAIL reset_int4_count: got %0d want 0", int4_count);
        end
    endtask

    task automatic run_frame(input bit ff, input bit gaps, input bit mid_start);
        int   t0, b, budget, extra;
        bit   xf;
        exp_t e;
        sb_q.push_back(model(ff));
        @(posedge clk); #1;
        start = 1'b1; force_full = ff; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; force_full = 1'b0;
        vectors++;
        if (busy !== 1'b1 || prec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL start_accept {busy,pv}: got %b%b want 10", busy, prec_valid);
        end
        b = 0; budget = 0;
        while (b < K && budget < 400) begin
            a_if.a_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            a_if.a_data  = frame_data[b];
            if (mid_start && b == 8) begin start = 1'b1; force_full = 1'b1; end
            xf = a_if.a_valid && a_if.a_ready;
            @(posedge clk); #1;
            start = 1'b0; force_full = 1'b0;
            if (xf) b++;
            budget++;
        end
        vectors++;
        if (b != K) begin
            miscompares++;
            $display("FAIL load_beats: got %0d transfers want %0d", b, K);
        end
        vectors++;
        if (a_if.a_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_after_last: got %b want 0", a_if.a_ready);
        end
        // Keep offering data while classifying; none of it may be accepted.
        a_if.a_valid = 1'b1; a_if.a_data = 16'hFFFF;
        extra = 0; budget = 0;
        while (done !== 1'b1 && budget < 50) begin
            if (a_if.a_valid && a_if.a_ready) extra++;
            @(posedge clk); #1;
            budget++;
        end
        a_if.a_valid = 1'b0;
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL extra_transfers: got %0d want 0", extra);
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout: done not seen within 50 cycles");
        end else begin
            if (!gaps) begin
                vectors++;
                if (cyc - t0 != K + L + 1) begin
                    miscompares++;
                    $display("FAIL done_latency: got %0d want %0d", cyc - t0, K + L + 1);
                end
            end
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard: done with no expected frame queued");
            end else begin
                e = sb_q.pop_front();
                for (int i = 0; i < L; i++) begin
                    vectors++;
                    if (token_precision[i] !== e.codes[i*4 +: 4]) begin
                        miscompares++;
                        $display("FAIL code[%0d]: got %0d want %0d", i, token_precision[i],
                                 e.codes[i*4 +: 4]);
                    end
                end
                vectors++;
                if (int4_count !== e.cnt) begin
                    miscompares++;
                    $display("FAIL int4_count: got %0d want %0d", int4_count, e.cnt);
                end
            end
            vectors++;
            if (prec_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL prec_valid_at_done: got %b want 1", prec_valid);
            end
        end
        @(posedge clk); #1;
        vectors++;
        if ({done, prec_valid, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL after_done {done,pv,busy}: got %b want 010", {done, prec_valid, busy});
        end
    endtask

    task automatic test_basic;
        set_cols(16'h0800, 16'h2000, 16'h4000, 16'h7FFF);
        run_frame(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_boundaries;
        set_cols(16'h0FFF, 16'h1000, 16'h3FFF, 16'h4000);
        run_frame(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps;
        set_cols(16'h0800, 16'h2000, 16'h4000, 16'h7FFF);
        run_frame(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_force_full;
        set_cols(16'h0800, 16'h2000, 16'h4000, 16'h7FFF);
        run_frame(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame;
        set_cols(16'h0800, 16'h2000, 16'h4000, 16'h7FFF);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 7; b++) begin
            a_if.a_valid = 1'b1; a_if.a_data = frame_data[b];
            @(posedge clk); #1;
        end
        a_if.a_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({busy, prec_valid, a_if.a_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_flags {busy,pv,rdy}: got %b want 000",
                     {busy, prec_valid, a_if.a_ready});
        end
        vectors++;
        if (token_precision[3] !== 4'd2) begin
            miscompares++;
            $display("FAIL abort_code[3]: got %0d want 2", token_precision[3]);
        end
        for (int b = 0; b < K; b++) frame_data[b] = 16'h0100;
        run_frame(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_boundaries;
        test_gaps;
        test_force_full;
        test_basic;
        test_reset_mid_frame;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d frames outstanding want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
